imem_uart_loader: RTL and testbench
===================================

Name: imem_uart_loader

Overview:
- Hardware boot-image writer: takes the received-byte stream from the UART receiver and packs it into little-endian 32-bit words.
- Writes those words sequentially into instruction/data memory starting at BASE_ADDR, using a valid/ready write port.
- Holds the core in reset while loading, then releases it so the core fetches the freshly written image.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of the first word written.
- NUM_BYTES, 256, image length in bytes; must be a nonzero multiple of 4.
- ADDR_W, 32, width of mem_addr.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- mem_we  output  1  write request; held until accepted.
- mem_addr  output  ADDR_W  word-aligned byte address.
- mem_wdata  output  32  write data.
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready.
- cpu_hold  output  1  core reset request; high while loading.
- busy  output  1  high in LOAD.
- done  output  1  sticky; set when the last word is accepted.
- overrun  output  1  sticky error flag.
- byte_cnt  output  $clog2(NUM_BYTES+1)  number of bytes received in the current load.

Behaviour:
- Reset (async, reset_n low): state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, busy=0, done=0, overrun=0, byte_cnt=0, assembly register and lane index cleared.
- States: IDLE, LOAD, DONE.
- IDLE: cpu_hold=1. On start: go to LOAD, clear byte_cnt, lane, done and overrun, and set the word pointer to BASE_ADDR.
- LOAD, byte packing:
  - Each rx_valid writes rx_data into lane[lane_idx] of the assembly register: first byte to [7:0], fourth byte to [31:24].
  - byte_cnt increments by 1 and lane_idx increments modulo 4.
- LOAD, word hand-off:
  - On the fourth byte, the completed word (including the byte arriving that cycle) is copied into mem_wdata.
  - mem_addr is set to the current pointer, and mem_we rises on the next cycle (1-cycle latency from the fourth strobe).
- Write handshake:
  - mem_we, mem_addr and mem_wdata stay stable until the cycle where mem_we && mem_ready.
  - mem_we drops the following cycle and the pointer advances by 4.
  - Byte packing continues in parallel while a write is pending.
- Overrun: if a fourth byte completes a word while the previous write is still unaccepted, the new word is discarded, overrun is set, and the pointer and pending write are left untouched. byte_cnt still counts that word's bytes.
- Simultaneous events: a fourth byte in the same cycle as the acceptance of the prior write is not an overrun. The new word loads into mem_wdata with mem_addr = old pointer + 4, and mem_we stays high.
- Completion: when the word containing byte NUM_BYTES is accepted, go to DONE. done=1, busy=0, and cpu_hold falls in that same cycle.
- Extra bytes in LOAD: bytes arriving after byte_cnt reaches NUM_BYTES (while the final write is pending) are ignored and byte_cnt saturates.
- DONE: cpu_hold=0. rx_valid is ignored. start re-enters LOAD exactly as from IDLE.
- start during LOAD is ignored.
- reset_n asserted mid-load aborts immediately to the reset values. Any partial word is lost, with no write issued.
- All outputs are registered.

Test Plan:
- Normal load, NUM_BYTES=8, mem_ready tied high: start, then bytes 0x13,0x00,0x00,0x00,0x37,0x05,0x00,0x20 → writes 32'h00000013 @0x10000000 and 32'h20000537 @0x10000004. mem_we is high exactly 1 cycle each, rising 1 cycle after the 4th and 8th strobes. done=1 and cpu_hold=0 after the second write.
- Backpressure: mem_ready low for 5 cycles after the first word → mem_we, addr and data stay stable for 6 cycles. The next 3 bytes are still packed, and the second word is written correctly with overrun=0.
- Overrun: mem_ready held low while 8 bytes arrive → overrun=1 and only word 0 remains pending at 0x10000000. After mem_ready rises, the pointer is 0x10000004 and word 1 was dropped.
- Simultaneous: the 8th byte strobe coincides with mem_ready acceptance of word 0 → no overrun, and mem_we stays high continuously for word 1 @0x10000004.
- Reset mid-load: reset_n low after 6 bytes → all outputs return to reset values immediately. A subsequent start plus 8 bytes loads from 0x10000000.
- Misc: rx_valid in IDLE and in DONE is ignored (byte_cnt unchanged). A second start from DONE clears done, reasserts cpu_hold, and reloads.

Source files
------------

// File: rtl/imem_uart_loader.sv
// Boot-image loader: packs UART bytes into little-endian words and writes them
// sequentially to memory, holding the core in reset until the image is complete.
module imem_uart_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1000_0000),
  parameter int unsigned       NUM_BYTES = 256
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic                           mem_ready,
  output logic                           cpu_hold,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt
);

  localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [31:0]         r_asm;
  logic [1:0]          r_lane;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_last_pend;

  logic                w_accept;
  logic                w_take;
  logic [31:0]         w_word;

  assign w_accept = mem_we && mem_ready;
  // Bytes beyond the image length are dropped so byte_cnt saturates
  assign w_take   = rx_valid && (byte_cnt < CNT_W'(NUM_BYTES));

  always_comb begin
    w_word = r_asm;
    w_word[{r_lane, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= 32'd0;
      cpu_hold    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      byte_cnt    <= '0;
      r_asm       <= 32'd0;
      r_lane      <= 2'd0;
      r_ptr       <= BASE_ADDR;
      r_last_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            byte_cnt    <= '0;
            r_lane      <= 2'd0;
            r_asm       <= 32'd0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            r_ptr       <= BASE_ADDR;
            busy        <= 1'b1;
            cpu_hold    <= 1'b1;
            r_last_pend <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            mem_we <= 1'b0;
            r_ptr  <= r_ptr + ADDR_W'(4);
            if (r_last_pend) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end
          end
          if (w_take) begin
            r_asm    <= w_word;
            r_lane   <= r_lane + 2'd1;
            byte_cnt <= byte_cnt + CNT_W'(1);
            // A completed word issues only if the write slot is free this cycle
            if (r_lane == 2'd3) begin
              if (!mem_we || w_accept) begin
                mem_we      <= 1'b1;
                mem_wdata   <= w_word;
                mem_addr    <= w_accept ? (r_ptr + ADDR_W'(4)) : r_ptr;
                r_last_pend <= (byte_cnt == CNT_W'(NUM_BYTES - 1));
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with an 8-byte image.
module tb_imem_uart_loader;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned NUM_BYTES = 8;
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [31:0] BASE      = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              overrun;
  logic [CNT_W-1:0]  byte_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  imem_uart_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .NUM_BYTES(NUM_BYTES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    64'(mem_we),    64'd0);
    chk({tag, "_addr"},  64'(mem_addr),  64'(BASE));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_hold"},  64'(cpu_hold),  64'd1);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_ovr"},   64'(overrun),   64'd0);
    chk({tag, "_cnt"},   64'(byte_cnt),  64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;
    tick();

    // Normal load with memory always ready
    mem_ready = 1'b1;
    send_byte(8'hEE);
    chk("idle_rx_cnt", 64'(byte_cnt), 64'd0);
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_hold", 64'(cpu_hold), 64'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    chk("t1_we_early", 64'(mem_we), 64'd0);
    send_byte(8'h00);
    chk("t1_w0_we",   64'(mem_we),    64'd1);
    chk("t1_w0_addr", 64'(mem_addr),  64'h1000_0000);
    chk("t1_w0_data", 64'(mem_wdata), 64'h0000_0013);
    chk("t1_cnt4",    64'(byte_cnt),  64'd4);
    send_byte(8'h37);
    chk("t1_w0_drop", 64'(mem_we), 64'd0);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h20);
    chk("t1_w1_we",   64'(mem_we),    64'd1);
    chk("t1_w1_addr", 64'(mem_addr),  64'h1000_0004);
    chk("t1_w1_data", 64'(mem_wdata), 64'h2000_0537);
    chk("t1_done_pre", 64'(done), 64'd0);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_hold_rel", 64'(cpu_hold), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);
    chk("t1_we_off", 64'(mem_we), 64'd0);
    send_byte(8'hAA);
    chk("done_rx_cnt", 64'(byte_cnt), 64'd8);

    // Backpressure: restart from DONE, memory stalls for 5 cycles
    mem_ready = 1'b0;
    pulse_start();
    chk("t2_done_clr", 64'(done), 64'd0);
    chk("t2_hold",     64'(cpu_hold), 64'd1);
    chk("t2_cnt0",     64'(byte_cnt), 64'd0);
    send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    chk("t2_start_ign", 64'(byte_cnt), 64'd2);
    send_byte(8'h33); send_byte(8'h44);
    chk("t2_stall0", {31'd0, mem_we, mem_addr}, {31'd1, 32'h1000_0000});
    for (int i = 0; i < 5; i++) begin
      if (i < 3) send_byte(8'(8'h55 + 8'(i * 17)));
      else tick();
      chk($sformatf("t2_stall%0d", i + 1), {mem_we, mem_addr, mem_wdata[30:0]},
          {1'b1, 32'h1000_0000, 31'h4433_2211});
    end
    chk("t2_cnt7", 64'(byte_cnt), 64'd7);
    mem_ready = 1'b1;
    tick();
    chk("t2_acc0", 64'(mem_we), 64'd0);
    send_byte(8'h88);
    chk("t2_w1_addr", 64'(mem_addr),  64'h1000_0004);
    chk("t2_w1_data", 64'(mem_wdata), 64'h8877_6655);
    chk("t2_w1_ovr",  64'(overrun),   64'd0);
    tick();
    chk("t2_done", 64'(done), 64'd1);

    // Overrun: memory never ready while both words arrive
    mem_ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("t3_ovr",  64'(overrun),   64'd1);
    chk("t3_we",   64'(mem_we),    64'd1);
    chk("t3_addr", 64'(mem_addr),  64'h1000_0000);
    chk("t3_data", 64'(mem_wdata), 64'h0403_0201);
    chk("t3_cnt",  64'(byte_cnt),  64'd8);
    mem_ready = 1'b1;
    tick();
    chk("t3_we_off", 64'(mem_we), 64'd0);
    chk("t3_no_done", 64'(done), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    send_byte(8'hFF);
    chk("t3_sat", 64'(byte_cnt), 64'd8);
    do_reset();
    chk("t3_rst_ovr", 64'(overrun), 64'd0);

    // Simultaneous 8th byte and acceptance of word 0
    mem_ready = 1'b0;
    pulse_start();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    chk("t4_pend", 64'(mem_we), 64'd1);
    mem_ready = 1'b1;
    send_byte(8'hB4);
    chk("t4_we",   64'(mem_we),    64'd1);
    chk("t4_addr", 64'(mem_addr),  64'h1000_0004);
    chk("t4_data", 64'(mem_wdata), 64'hB4B3_B2B1);
    chk("t4_ovr",  64'(overrun),   64'd0);
    tick();
    chk("t4_done", 64'(done), 64'd1);

    // Reset mid-load, then a clean reload
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + 8'(i)));
    chk("t5_cnt6", 64'(byte_cnt), 64'd6);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'hD0); send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
    chk("t5_w0_addr", 64'(mem_addr),  64'h1000_0000);
    chk("t5_w0_data", 64'(mem_wdata), 64'hD3D2_D1D0);
    send_byte(8'hE0); send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
    chk("t5_w1_addr", 64'(mem_addr),  64'h1000_0004);
    chk("t5_w1_data", 64'(mem_wdata), 64'hE3E2_E1E0);
    tick();
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_hold", 64'(cpu_hold), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
